// File: rtl/ex_mem_stage_pkg.sv
// Shared pipeline encodings: ALU op codes, destination/writeback selects and
// the EX/MEM control bundle.
package ex_mem_stage_pkg;

  localparam int unsigned ALU_OP_W = 3;
  localparam int unsigned SEL_W    = 2;
  localparam int unsigned LINK_REG = 31;
  localparam int unsigned SLL_AMT  = 16;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_SLT  = 3'b100,
    ALU_NOR  = 3'b101,
    ALU_SLL  = 3'b110,
    ALU_PASS = 3'b111
  } alu_op_e;

  typedef enum logic [SEL_W-1:0] {
    DST_RT     = 2'b00,
    DST_RD     = 2'b01,
    DST_LINK   = 2'b10,
    DST_RT_ALT = 2'b11
  } reg_dst_e;

  typedef enum logic [SEL_W-1:0] {
    WB_SEL_ALU  = 2'b00,
    WB_SEL_MEM  = 2'b01,
    WB_SEL_PC4  = 2'b10,
    WB_SEL_RSVD = 2'b11
  } mem_to_reg_e;

  typedef struct packed {
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    mem_to_reg_e mem_to_reg;
  } exm_ctrl_t;

endpackage

// File: rtl/ex_alu.sv
// Combinational execute-stage ALU with zero flag.
module ex_alu
  import ex_mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  alu_op_e           i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_result,
  output logic              o_zero
);

  always_comb begin
    o_result = '0;
    case (i_op)
      ALU_ADD:  o_result = i_a + i_b;
      ALU_SUB:  o_result = i_a - i_b;
      ALU_AND:  o_result = i_a & i_b;
      ALU_OR:   o_result = i_a | i_b;
      ALU_SLT:  o_result = DATA_W'($signed(i_a) < $signed(i_b));
      ALU_NOR:  o_result = ~(i_a | i_b);
      ALU_SLL:  o_result = i_b << SLL_AMT;
      ALU_PASS: o_result = i_b;
      default:  o_result = '0;
    endcase
  end

  assign o_zero = (o_result == '0);

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage with operand forwarding, load-use detection and the EX/MEM
// pipeline register.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RA_W   = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [2:0]        alu_operation,
  input  logic              alu_src,
  input  logic              reg__write,
  input  logic              mem__read,
  input  logic              mem__write,
  input  logic [1:0]        reg__destination,
  input  logic [1:0]        mem__to_reg,
  input  logic [DATA_W-1:0] read_data1,
  input  logic [DATA_W-1:0] read_data2,
  input  logic [DATA_W-1:0] sign_ext,
  input  logic [DATA_W-1:0] adder1,
  input  logic [RA_W-1:0]   Rs,
  input  logic [RA_W-1:0]   Rt,
  input  logic [RA_W-1:0]   Rd,
  input  logic [RA_W-1:0]   ifid_rs,
  input  logic [RA_W-1:0]   ifid_rt,
  input  logic              wb_reg_write,
  input  logic [RA_W-1:0]   wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              hold,
  input  logic              flush,
  output logic              load_use_stall,
  output logic [DATA_W-1:0] exm_alu_result,
  output logic [DATA_W-1:0] exm_store_data,
  output logic [DATA_W-1:0] exm_pc4,
  output logic [RA_W-1:0]   exm_dest,
  output logic              exm_zero,
  output logic              exm_reg_write,
  output logic              exm_mem_read,
  output logic              exm_mem_write,
  output logic [1:0]        exm_mem_to_reg
);

  logic [DATA_W-1:0] r_alu_result;
  logic [DATA_W-1:0] r_store_data;
  logic [DATA_W-1:0] r_pc4;
  logic [RA_W-1:0]   r_dest;
  logic              r_zero;
  exm_ctrl_t         r_ctrl;

  logic              w_exm_fwd_ok;
  logic              w_exm_hit_a;
  logic              w_exm_hit_b;
  logic              w_wb_hit_a;
  logic              w_wb_hit_b;
  logic [DATA_W-1:0] w_fwd_a;
  logic [DATA_W-1:0] w_fwd_b;
  logic [DATA_W-1:0] w_alu_b;
  logic [DATA_W-1:0] w_alu_result;
  logic              w_alu_zero;
  logic [RA_W-1:0]   w_dest;
  exm_ctrl_t         w_ctrl;

  // A load in EX/MEM holds an address, not data, so it never forwards.
  assign w_exm_fwd_ok = r_ctrl.reg_write && (r_dest != '0) && !r_ctrl.mem_read;
  assign w_exm_hit_a  = w_exm_fwd_ok && (r_dest == Rs);
  assign w_exm_hit_b  = w_exm_fwd_ok && (r_dest == Rt);
  assign w_wb_hit_a   = wb_reg_write && (wb_dest != '0) && (wb_dest == Rs);
  assign w_wb_hit_b   = wb_reg_write && (wb_dest != '0) && (wb_dest == Rt);

  always_comb begin
    w_fwd_a = read_data1;
    if (w_exm_hit_a)     w_fwd_a = r_alu_result;
    else if (w_wb_hit_a) w_fwd_a = wb_data;
  end

  always_comb begin
    w_fwd_b = read_data2;
    if (w_exm_hit_b)     w_fwd_b = r_alu_result;
    else if (w_wb_hit_b) w_fwd_b = wb_data;
  end

  assign w_alu_b = alu_src ? sign_ext : w_fwd_b;

  ex_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .i_op     (alu_op_e'(alu_operation)),
    .i_a      (w_fwd_a),
    .i_b      (w_alu_b),
    .o_result (w_alu_result),
    .o_zero   (w_alu_zero)
  );

  always_comb begin
    w_dest = Rt;
    case (reg_dst_e'(reg__destination))
      DST_RT:     w_dest = Rt;
      DST_RD:     w_dest = Rd;
      DST_LINK:   w_dest = RA_W'(LINK_REG);
      DST_RT_ALT: w_dest = Rt;
      default:    w_dest = Rt;
    endcase
  end

  assign w_ctrl = '{
    reg_write:  reg__write,
    mem_read:   mem__read,
    mem_write:  mem__write,
    mem_to_reg: mem_to_reg_e'(mem__to_reg)
  };

  assign load_use_stall = mem__read && reg__write && (Rt != '0) &&
                          ((Rt == ifid_rs) || (Rt == ifid_rt));

  // Reset beats hold, hold beats flush.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_alu_result <= '0;
      r_store_data <= '0;
      r_pc4        <= '0;
      r_dest       <= '0;
      r_zero       <= 1'b0;
      r_ctrl       <= '0;
    end else if (!hold) begin
      if (flush) begin
        r_alu_result <= '0;
        r_store_data <= '0;
        r_pc4        <= '0;
        r_dest       <= '0;
        r_zero       <= 1'b0;
        r_ctrl       <= '0;
      end else begin
        r_alu_result <= w_alu_result;
        r_store_data <= w_fwd_b;
        r_pc4        <= adder1;
        r_dest       <= w_dest;
        r_zero       <= w_alu_zero;
        r_ctrl       <= w_ctrl;
      end
    end
  end

  assign exm_alu_result = r_alu_result;
  assign exm_store_data = r_store_data;
  assign exm_pc4        = r_pc4;
  assign exm_dest       = r_dest;
  assign exm_zero       = r_zero;
  assign exm_reg_write  = r_ctrl.reg_write;
  assign exm_mem_read   = r_ctrl.mem_read;
  assign exm_mem_write  = r_ctrl.mem_write;
  assign exm_mem_to_reg = r_ctrl.mem_to_reg;

endmodule
